// File: rtl/exe_mem_req_pkg.sv
// Shared definitions for the EXE-stage memory request block: access size
// encodings, the per-request tag carried through the in-order queue, default
// geometry and the byte-lane mask helper.
package exe_mem_req_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int OUTSTANDING_DEF = 2;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Everything needed to post-process a response once it comes back.
    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic       sext;
        logic [2:0] offset;
        logic       discard;
    } mem_tag_t;

    // Unshifted byte-enable pattern for an access of the given size.
    function automatic logic [7:0] lane_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/exe_mem_req_tag_fifo.sv
// In-order queue of request tags for accepted-but-unanswered memory accesses.
// A flush marks every slot as discard so the matching responses are dropped
// when they eventually arrive; pops on an empty queue are ignored.
module req_tag_fifo
    import exe_mem_req_pkg::*;
#(
    parameter int DEPTH = OUTSTANDING_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  mem_tag_t         push_tag,
    input  logic             pop,
    input  logic             flush,
    output mem_tag_t         head_tag,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    mem_tag_t           tags_reg [DEPTH];
    logic [DEPTH-1:0]   discard_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               push_eff;
    logic               pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign count    = count_reg;
    assign push_eff = push & ~full;
    assign pop_eff  = pop & ~empty;

    // Head tag with its live discard flag merged in.
    always_comb begin
        head_tag         = tags_reg[rd_ptr_reg];
        head_tag.discard = discard_reg[rd_ptr_reg];
    end

    // Occupancy bookkeeping; a push and pop together leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_eff, pop_eff})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Tag storage is not reset; occupancy decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            tags_reg[wr_ptr_reg] <= push_tag;
        end
    end

    // Pointers, count and discard flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            discard_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push_eff) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_eff) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            // Marking empty slots too is harmless: a push overwrites its flag.
            if (flush) begin
                discard_reg <= '1;
            end
            if (push_eff) begin
                discard_reg[wr_ptr_reg] <= push_tag.discard | flush;
            end
        end
    end

endmodule

// File: rtl/exe_mem_req.sv
// EXE-stage memory request generator: alignment check, store byte strobes
// and lane replication, an in-order tag queue bounding outstanding requests,
// and load result alignment/extension on the response path.
module exe_mem_req
    import exe_mem_req_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OUTSTANDING = OUTSTANDING_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wr,
    input  logic [1:0]          in_size,
    input  logic                in_sext,
    input  logic [31:0]         in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                flush,
    output logic                ale,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [31:0]         addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    logic              misaligned;
    logic              live;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    mem_tag_t          push_tag;
    mem_tag_t          head_tag;
    logic [2:0]        head_off;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;
    logic              rsp_fire;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;

    // Alignment check; a dword on a 32-bit bus can never be issued.
    always_comb begin
        case (in_size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = in_addr[0];
            SIZE_W:  misaligned = |in_addr[1:0];
            default: misaligned = (DATA_W == 32) ? 1'b1 : |in_addr[2:0];
        endcase
    end

    // Handshake: misaligned accesses are consumed locally and raise ale.
    assign live     = resetn & in_valid & ~flush;
    assign ale      = live & misaligned;
    assign req      = live & ~misaligned & ~fifo_full;
    assign in_ready = ale | (req & addr_ok);
    assign busy     = resetn & ~fifo_empty;

    assign wr    = in_wr;
    assign size  = in_size;
    assign addr  = in_addr;
    assign wstrb = in_wr ? NB'(lane_mask(in_size) << (in_addr[2:0] & 3'(NB - 1))) : '0;

    // Each byte lane receives the matching byte of the low-order store data.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign wdata[8*gi +: 8] =
            (in_size == SIZE_B) ? in_wdata[7:0] :
            (in_size == SIZE_H) ? in_wdata[8*(gi % 2) +: 8] :
            (in_size == SIZE_W) ? in_wdata[8*(gi % 4) +: 8] :
                                  in_wdata[8*gi +: 8];
    end

    assign push_tag = '{wr: in_wr, size: in_size, sext: in_sext,
                        offset: in_addr[2:0], discard: 1'b0};

    req_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (req & addr_ok),
        .push_tag (push_tag),
        .pop      (data_ok),
        .flush    (flush),
        .head_tag (head_tag),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Move the addressed bytes down to bit 0 of the response.
    assign head_off = head_tag.offset & 3'(NB - 1);
    assign shifted  = rdata >> {head_off, 3'b000};

    // Zero/sign extension according to the queued access size.
    always_comb begin
        ext = shifted;
        case (head_tag.size)
            SIZE_B: begin
                ext      = {DATA_W{head_tag.sext & shifted[7]}};
                ext[7:0] = shifted[7:0];
            end
            SIZE_H: begin
                ext       = {DATA_W{head_tag.sext & shifted[15]}};
                ext[15:0] = shifted[15:0];
            end
            SIZE_W: begin
                ext       = {DATA_W{head_tag.sext & shifted[31]}};
                ext[31:0] = shifted[31:0];
            end
            default: ext = shifted;
        endcase
    end

    // A flush in the same cycle as the response also cancels that load.
    assign rsp_fire = data_ok & ~fifo_empty & ~head_tag.wr & ~head_tag.discard & ~flush;

    // Registered single-cycle load result; data holds between results.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= rsp_fire;
            if (rsp_fire) begin
                rsp_data_reg <= ext;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;

    // Occupancy is observed through busy; the raw count is kept for debug.
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule
